difftest_step_scheduler: RTL and testbench
==========================================

Name: difftest_step_scheduler

Overview:
- Synthesizable replacement for per-cycle difftest stepping in emulation builds (Palladium/FPGA) under SimTop's testbench.
- Accumulates the DUT's per-cycle commit step counts into batches and queues them in a small FIFO.
- Hands batches to the host-side checker over a valid/ready channel and tracks outstanding results.
- Stalls the DUT on back-pressure; sequences init, run, drain and finish, and reports a finish cause to the testbench.

Parameters:
STEP_WIDTH, 8, width of per-cycle step input
ACC_WIDTH, 16, batch counter width; must satisfy 2^ACC_WIDTH > BATCH_MAX + 2^STEP_WIDTH
BATCH_MAX, 64, flush threshold in steps
TIMEOUT, 1024, max cycles a non-zero partial batch may wait before forced flush (>=2)
FIFO_DEPTH, 4, batch FIFO entries (power of 2)
OUTST_MAX, 8, max batches accepted by checker without result

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low reset
step_in  in  STEP_WIDTH  steps committed by DUT this cycle
stall  out  1  DUT must hold state; step_in is ignored while 1
max_cycles  in  64  cycle limit, 0 = unlimited (quasi-static)
init_req  out  1  request checker init
init_ack  in  1  checker init complete (1-cycle pulse)
chk_valid  out  1  batch available
chk_ready  in  1  checker accepts batch
chk_steps  out  ACC_WIDTH  batch step count
res_valid  in  1  one check result returned
res_fail  in  1  result is a mismatch (qualified by res_valid)
n_cycles  out  64  cycles counted since leaving INIT
finish_valid  out  1  simulation must end (sticky)
finish_code  out  2  0 none, 1 difftest fail, 2 max cycles
fail_cycle  out  64  n_cycles value at the first failing result

Behaviour:
- Reset (reset==0): state INIT; stall=1, init_req=0, chk_valid=0, finish_valid=0, finish_code=0, n_cycles=0, fail_cycle=0; accumulator, timer, FIFO and outstanding counter cleared. Reset mid-operation discards all batches; no results are expected afterwards.
- States: INIT -> RUN -> DRAIN -> DONE.
- INIT:
  - init_req registered; it rises the first cycle after reset release and holds until init_ack.
  - On init_ack, init_req falls and the state is RUN next cycle.
  - stall=1 throughout INIT.
- RUN:
  - n_cycles increments every cycle in RUN and DRAIN, including stalled cycles.
  - acc_next = acc + step_in when stall==0, else acc.
  - Flush condition: acc_next >= BATCH_MAX, or (timer == TIMEOUT-1 and acc_next != 0).
  - Flush with FIFO not full: push acc_next, acc <= 0, timer <= 0.
  - Flush with FIFO full: acc <= acc_next, stall <= 1 next cycle.
  - A pop in the same cycle does not free space for a push in that cycle.
  - Timer increments while acc_next != 0 and no push; it is held at 0 while acc_next == 0.
  - While stall==1, acc is pushed on the first cycle the FIFO is not full; stall deasserts the following cycle.
- Checker channel:
  - chk_valid = FIFO non-empty and outstanding < OUTST_MAX; chk_steps = FIFO head.
  - Pop on chk_valid && chk_ready; the outstanding counter increments on pop and decrements on res_valid. Simultaneous pop and result leave it unchanged.
  - chk_steps must stay stable while chk_valid && !chk_ready.
- Failure:
  - First res_valid && res_fail in RUN or DRAIN: fail_cycle <= n_cycles, finish_code <= 1, go to DONE next cycle. Later fails are ignored.
- Max cycles:
  - In RUN with max_cycles != 0 and n_cycles >= max_cycles, enter DRAIN. stall=1 from that cycle onward.
  - The remaining non-zero acc is pushed as a final batch when space allows.
- DRAIN: when acc==0, FIFO empty and outstanding==0, set finish_code=2 and go to DONE. A failing result during DRAIN takes priority (code 1).
- DONE: finish_valid=1 (sticky), stall=1, chk_valid=0, n_cycles frozen. Results arriving in DONE are ignored.
- Batches are never zero-valued; zero step_in cycles never create pushes.

Test Plan:
- Threshold flush: after init, step_in=8 for 8 cycles, ready=1 -> one batch chk_steps=64 at cycle 8, acc=0, no stall.
- Timeout flush (TIMEOUT=16): step_in=3 once then 0 -> chk_steps=3 presented exactly 16 cycles after the step; no further batches.
- Back-pressure: chk_ready=0, step_in=64 each cycle -> 4 pushes, stall=1 on the cycle after the 5th flush attempt; ready=1 for one cycle -> 5th batch pushed, stall=0 one cycle later, no steps lost (sum of chk_steps == sum of accepted step_in).
- Outstanding limit (OUTST_MAX=2): ready=1, no results -> chk_valid drops after 2 pops; one res_valid -> exactly one more pop.
- Fail: res_fail on second result at n_cycles=37 -> fail_cycle=37, finish_code=1, finish_valid sticky, stall=1.
- Max cycles=100 with acc=5 pending and 1 outstanding -> DRAIN pushes 5; after both results pass, finish_code=2. Repeat with reset asserted mid-RUN -> all outputs return to reset values and INIT restarts.

Source files
------------

// File: rtl/difftest_step_scheduler_if.sv
// Checker-side channel of the difftest step scheduler: batch hand-off
// (valid/ready with step count) plus the returned check results.
interface difftest_step_scheduler_if #(
    parameter int ACC_WIDTH = 16
);
    logic                 chk_valid;
    logic                 chk_ready;
    logic [ACC_WIDTH-1:0] chk_steps;
    logic                 res_valid;
    logic                 res_fail;

    modport master (
        output chk_valid,
        output chk_steps,
        input  chk_ready,
        input  res_valid,
        input  res_fail
    );

    modport slave (
        input  chk_valid,
        input  chk_steps,
        output chk_ready,
        output res_valid,
        output res_fail
    );
endinterface

// File: rtl/difftest_step_scheduler.sv
// difftest_step_scheduler: accumulates per-cycle commit step counts into
// batches, queues them for the host checker, stalls the DUT on back-pressure
// and sequences init / run / drain / done with a finish cause.
module difftest_step_scheduler #(
    parameter int STEP_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int BATCH_MAX  = 64,
    parameter int TIMEOUT    = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int OUTST_MAX  = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [STEP_WIDTH-1:0]       step_in,
    output logic                        stall,
    input  logic [63:0]                 max_cycles,
    output logic                        init_req,
    input  logic                        init_ack,
    difftest_step_scheduler_if.master   chk,
    output logic [63:0]                 n_cycles,
    output logic                        finish_valid,
    output logic [1:0]                  finish_code,
    output logic [63:0]                 fail_cycle
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OST_W = $clog2(OUTST_MAX + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [ACC_WIDTH-1:0] acc_r, acc_s, acc_next_s, push_data_s;
    logic [TMR_W-1:0]     timer_r, timer_s;
    logic                 stall_r, stall_s;
    logic                 init_req_r, init_req_s;
    logic [PTR_W-1:0]     wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0]     fcnt_r, fcnt_s;
    logic [OST_W-1:0]     outst_r, outst_s;
    logic [63:0]          n_cycles_r, n_cycles_s, fail_cycle_r, fail_cycle_s;
    logic                 finish_valid_r, finish_valid_s;
    logic [1:0]           finish_code_r, finish_code_s;
    logic [ACC_WIDTH-1:0] mem_r [FIFO_DEPTH];

    logic fifo_full_s, fifo_empty_s, active_s, chk_valid_s, pop_s;
    logic push_s, push_req_s, res_dec_s, fail_s, flush_s;

    // Channel status and flush decision, derived from registered state and inputs.
    always_comb begin
        fifo_full_s  = (fcnt_r == CNT_W'(FIFO_DEPTH));
        fifo_empty_s = (fcnt_r == {CNT_W{1'b0}});
        active_s     = (state_r == ST_RUN) || (state_r == ST_DRAIN);
        chk_valid_s  = active_s && !fifo_empty_s && (outst_r < OST_W'(OUTST_MAX));
        pop_s        = chk_valid_s && chk.chk_ready;
        res_dec_s    = active_s && chk.res_valid && (outst_r != {OST_W{1'b0}});
        fail_s       = active_s && chk.res_valid && chk.res_fail;
        // Steps offered while stalled are not taken: the DUT repeats them.
        acc_next_s   = stall_r ? acc_r : (acc_r + ACC_WIDTH'(step_in));
        flush_s      = (acc_next_s >= ACC_WIDTH'(BATCH_MAX)) ||
                       ((timer_r == TMR_W'(TIMEOUT - 1)) && (acc_next_s != {ACC_WIDTH{1'b0}}));
    end

    // Sequencer: next state, accumulator, timer, stall and finish reporting.
    always_comb begin
        state_s        = state_r;
        acc_s          = acc_r;
        timer_s        = timer_r;
        stall_s        = stall_r;
        init_req_s     = init_req_r;
        n_cycles_s     = n_cycles_r;
        fail_cycle_s   = fail_cycle_r;
        finish_valid_s = finish_valid_r;
        finish_code_s  = finish_code_r;
        push_req_s     = 1'b0;
        push_s         = 1'b0;
        push_data_s    = acc_next_s;
        case (state_r)
            ST_INIT: begin
                stall_s = 1'b1;
                if (init_req_r && init_ack) begin
                    init_req_s = 1'b0;
                    stall_s    = 1'b0;
                    state_s    = ST_RUN;
                end else begin
                    init_req_s = 1'b1;
                end
            end
            ST_RUN: begin
                n_cycles_s = n_cycles_r + 64'd1;
                // A stalled cycle keeps retrying the pending batch until space opens.
                push_req_s = flush_s || (stall_r && (acc_r != {ACC_WIDTH{1'b0}}));
                // Occupancy is taken before any pop of this cycle.
                push_s     = push_req_s && !fifo_full_s;
                if (push_s) begin
                    acc_s   = {ACC_WIDTH{1'b0}};
                    timer_s = {TMR_W{1'b0}};
                    stall_s = 1'b0;
                end else begin
                    acc_s   = acc_next_s;
                    stall_s = push_req_s;
                    if (acc_next_s == {ACC_WIDTH{1'b0}}) begin
                        timer_s = {TMR_W{1'b0}};
                    end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
                        timer_s = timer_r;
                    end else begin
                        timer_s = timer_r + TMR_W'(1);
                    end
                end
                if (fail_s) begin
                    state_s        = ST_DONE;
                    finish_valid_s = 1'b1;
                    finish_code_s  = 2'd1;
                    fail_cycle_s   = n_cycles_r;
                    stall_s        = 1'b1;
                end else if ((max_cycles != 64'd0) && (n_cycles_r >= max_cycles)) begin
                    state_s = ST_DRAIN;
                    stall_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                n_cycles_s  = n_cycles_r + 64'd1;
                stall_s     = 1'b1;
                timer_s     = {TMR_W{1'b0}};
                push_data_s = acc_r;
                push_s      = (acc_r != {ACC_WIDTH{1'b0}}) && !fifo_full_s;
                if (push_s) begin
                    acc_s = {ACC_WIDTH{1'b0}};
                end else begin
                    acc_s = acc_r;
                end
                if (fail_s) begin
                    state_s        = ST_DONE;
                    finish_valid_s = 1'b1;
                    finish_code_s  = 2'd1;
                    fail_cycle_s   = n_cycles_r;
                end else if ((acc_r == {ACC_WIDTH{1'b0}}) && fifo_empty_s &&
                             (outst_r == {OST_W{1'b0}})) begin
                    state_s        = ST_DONE;
                    finish_valid_s = 1'b1;
                    finish_code_s  = 2'd2;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                stall_s = 1'b1;
            end
            default: begin
                state_s = ST_INIT;
                stall_s = 1'b1;
            end
        endcase
    end

    // FIFO pointers/occupancy and outstanding-result bookkeeping.
    always_comb begin
        wr_ptr_s = push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
        rd_ptr_s = pop_s  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        if (push_s && !pop_s) begin
            fcnt_s = fcnt_r + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            fcnt_s = fcnt_r - CNT_W'(1);
        end else begin
            fcnt_s = fcnt_r;
        end
        if (pop_s && !res_dec_s) begin
            outst_s = outst_r + OST_W'(1);
        end else if (!pop_s && res_dec_s) begin
            outst_s = outst_r - OST_W'(1);
        end else begin
            outst_s = outst_r;
        end
    end

    // Register all control state; reset is synchronous and active-low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r        <= ST_INIT;
            acc_r          <= {ACC_WIDTH{1'b0}};
            timer_r        <= {TMR_W{1'b0}};
            stall_r        <= 1'b1;
            init_req_r     <= 1'b0;
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            fcnt_r         <= {CNT_W{1'b0}};
            outst_r        <= {OST_W{1'b0}};
            n_cycles_r     <= 64'd0;
            fail_cycle_r   <= 64'd0;
            finish_valid_r <= 1'b0;
            finish_code_r  <= 2'd0;
        end else begin
            state_r        <= state_s;
            acc_r          <= acc_s;
            timer_r        <= timer_s;
            stall_r        <= stall_s;
            init_req_r     <= init_req_s;
            wr_ptr_r       <= wr_ptr_s;
            rd_ptr_r       <= rd_ptr_s;
            fcnt_r         <= fcnt_s;
            outst_r        <= outst_s;
            n_cycles_r     <= n_cycles_s;
            fail_cycle_r   <= fail_cycle_s;
            finish_valid_r <= finish_valid_s;
            finish_code_r  <= finish_code_s;
        end
    end

    // Batch storage; entries are only meaningful between push and pop.
    always_ff @(posedge clock) begin
        if (reset && push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    assign stall         = stall_r;
    assign init_req      = init_req_r;
    assign chk.chk_valid = chk_valid_s;
    assign chk.chk_steps = mem_r[rd_ptr_r];
    assign n_cycles      = n_cycles_r;
    assign finish_valid  = finish_valid_r;
    assign finish_code   = finish_code_r;
    assign fail_cycle    = fail_cycle_r;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Bench for difftest_step_scheduler: directed scenarios with a batch
// scoreboard checked by an independent handshake monitor.
module tb_difftest_step_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  step_in;
    logic        stall;
    logic [63:0] max_cycles;
    logic        init_req;
    logic        init_ack;
    logic [63:0] n_cycles;
    logic        finish_valid;
    logic [1:0]  finish_code;
    logic [63:0] fail_cycle;

    difftest_step_scheduler_if #(.ACC_WIDTH(16)) chk_if ();

    difftest_step_scheduler #(
        .STEP_WIDTH(8), .ACC_WIDTH(16), .BATCH_MAX(64),
        .TIMEOUT(16), .FIFO_DEPTH(4), .OUTST_MAX(2)
    ) dut (
        .clock(clock), .reset(reset), .step_in(step_in), .stall(stall),
        .max_cycles(max_cycles), .init_req(init_req), .init_ack(init_ack),
        .chk(chk_if), .n_cycles(n_cycles), .finish_valid(finish_valid),
        .finish_code(finish_code), .fail_cycle(fail_cycle)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    int          got_sum = 0;
    int          acc_sum = 0;
    logic [15:0] exp_q [$];

    // Monitor: every accepted batch is compared with the next expected one.
    always @(negedge clock) begin
        if (reset && chk_if.chk_valid && chk_if.chk_ready) begin
            pops++;
            checks++;
            got_sum += int'(chk_if.chk_steps);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL batch_unexpected: got chk_steps=%0d, none expected", chk_if.chk_steps);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (chk_if.chk_steps !== e) begin
                    errors++;
                    $display("FAIL batch_value: got chk_steps=%0d expected=%0d", chk_if.chk_steps, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0b expected=%0b", name, got, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk1("rst_stall", stall, 1'b1);
        chk1("rst_init_req", init_req, 1'b0);
        chk1("rst_chk_valid", chk_if.chk_valid, 1'b0);
        chk1("rst_finish_valid", finish_valid, 1'b0);
        chk64("rst_finish_code", 64'(finish_code), 64'd0);
        chk64("rst_n_cycles", n_cycles, 64'd0);
        chk64("rst_fail_cycle", fail_cycle, 64'd0);
    endtask

    task automatic do_init();
        reset = 1'b1;
        tick(1);
        chk1("init_req_rise", init_req, 1'b1);
        tick(1);
        chk1("init_req_hold", init_req, 1'b1);
        chk1("init_stall", stall, 1'b1);
        init_ack = 1'b1;
        tick(1);
        init_ack = 1'b0;
        chk1("init_req_fall", init_req, 1'b0);
        chk1("run_stall", stall, 1'b0);
        chk64("run_n_cycles", n_cycles, 64'd0);
    endtask

    task automatic wait_n(input logic [63:0] target);
        int k;
        k = 0;
        while (n_cycles != target && k < 500) begin
            tick(1);
            k++;
        end
        chk64("wait_n_cycles", n_cycles, target);
    endtask

    task automatic result_pulse(input logic fail);
        chk_if.res_valid = 1'b1;
        chk_if.res_fail  = fail;
        tick(1);
        chk_if.res_valid = 1'b0;
        chk_if.res_fail  = 1'b0;
    endtask

    initial begin
        int p0;
        int k;
        reset = 1'b0; step_in = 8'd0; max_cycles = 64'd0; init_ack = 1'b0;
        chk_if.chk_ready = 1'b0; chk_if.res_valid = 1'b0; chk_if.res_fail = 1'b0;
        tick(3);
        check_reset_vals();
        do_init();

        // Threshold flush: 8 x 8 steps form one 64-step batch.
        chk_if.chk_ready = 1'b1;
        step_in = 8'd8;
        exp_q.push_back(16'd64); acc_sum += 64;
        tick(7);
        chk1("thr_not_yet", chk_if.chk_valid, 1'b0);
        tick(1);
        step_in = 8'd0;
        chk1("thr_valid", chk_if.chk_valid, 1'b1);
        chk1("thr_no_stall", stall, 1'b0);
        tick(1);
        chk1("thr_popped", chk_if.chk_valid, 1'b0);
        result_pulse(1'b0);

        // Timeout flush: a lone 3 is presented 16 cycles after the step.
        step_in = 8'd3;
        exp_q.push_back(16'd3); acc_sum += 3;
        tick(1);
        step_in = 8'd0;
        tick(14);
        chk1("tmo_not_yet", chk_if.chk_valid, 1'b0);
        tick(1);
        chk1("tmo_valid", chk_if.chk_valid, 1'b1);
        tick(1);
        result_pulse(1'b0);
        tick(20);
        chk1("tmo_no_extra", chk_if.chk_valid, 1'b0);

        // Back-pressure: checker not ready, 64 steps per cycle.
        chk_if.chk_ready = 1'b0;
        step_in = 8'd64;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(16'd64);
        end
        acc_sum += 320;
        tick(4);
        chk1("bp_four_pushed_no_stall", stall, 1'b0);
        tick(1);
        chk1("bp_stall_set", stall, 1'b1);
        tick(1);
        chk1("bp_stall_held", stall, 1'b1);
        chk_if.chk_ready = 1'b1;
        step_in = 8'd0;
        tick(1);
        chk_if.chk_ready = 1'b0;
        chk1("bp_pop_no_same_cycle_space", stall, 1'b1);
        tick(1);
        chk1("bp_stall_released", stall, 1'b0);

        // Outstanding limit of 2: one already outstanding, one more pop then stop.
        p0 = pops;
        chk_if.chk_ready = 1'b1;
        tick(4);
        chk1("ost_valid_dropped", chk_if.chk_valid, 1'b0);
        chk64("ost_pops_to_limit", 64'(pops - p0), 64'd1);
        result_pulse(1'b0);
        tick(3);
        chk64("ost_one_more_pop", 64'(pops - p0), 64'd2);
        chk1("ost_valid_dropped_again", chk_if.chk_valid, 1'b0);
        chk_if.res_valid = 1'b1;
        tick(10);
        chk_if.res_valid = 1'b0;
        chk64("bp_sb_empty", 64'(exp_q.size()), 64'd0);
        chk64("bp_no_steps_lost", 64'(got_sum), 64'(acc_sum));

        // Failure on second result at n_cycles = 37.
        reset = 1'b0;
        tick(2);
        check_reset_vals();
        do_init();
        step_in = 8'd64;
        exp_q.push_back(16'd64); exp_q.push_back(16'd64); acc_sum += 128;
        tick(2);
        step_in = 8'd0;
        tick(2);
        result_pulse(1'b0);
        wait_n(64'd37);
        result_pulse(1'b1);
        chk1("fail_finish_valid", finish_valid, 1'b1);
        chk64("fail_code", 64'(finish_code), 64'd1);
        chk64("fail_cycle", fail_cycle, 64'd37);
        chk1("fail_stall", stall, 1'b1);
        chk1("fail_no_valid", chk_if.chk_valid, 1'b0);
        tick(1);
        result_pulse(1'b1);
        tick(3);
        chk1("fail_sticky", finish_valid, 1'b1);
        chk64("fail_cycle_kept", fail_cycle, 64'd37);
        chk64("fail_n_frozen", n_cycles, 64'd38);

        // Max cycles = 100 with 5 steps pending and one batch outstanding.
        reset = 1'b0;
        tick(2);
        check_reset_vals();
        max_cycles = 64'd100;
        do_init();
        step_in = 8'd64;
        exp_q.push_back(16'd64); acc_sum += 64;
        tick(1);
        step_in = 8'd0;
        tick(2);
        wait_n(64'd95);
        step_in = 8'd5;
        exp_q.push_back(16'd5); acc_sum += 5;
        tick(1);
        step_in = 8'd0;
        wait_n(64'd101);
        chk1("drain_stall", stall, 1'b1);
        chk1("drain_not_finished", finish_valid, 1'b0);
        tick(3);
        chk_if.res_valid = 1'b1;
        tick(2);
        chk_if.res_valid = 1'b0;
        k = 0;
        while (!finish_valid && k < 20) begin
            tick(1);
            k++;
        end
        chk1("max_finish_valid", finish_valid, 1'b1);
        chk64("max_finish_code", 64'(finish_code), 64'd2);
        chk64("max_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset asserted mid-RUN discards the partial batch and restarts INIT.
        reset = 1'b0;
        tick(2);
        do_init();
        step_in = 8'd10;
        tick(3);
        step_in = 8'd0;
        tick(5);
        reset = 1'b0;
        tick(2);
        check_reset_vals();
        reset = 1'b1;
        tick(1);
        chk1("restart_init_req", init_req, 1'b1);
        init_ack = 1'b1;
        tick(1);
        init_ack = 1'b0;
        step_in = 8'd64;
        exp_q.push_back(16'd64); acc_sum += 64;
        tick(1);
        step_in = 8'd0;
        tick(3);
        chk64("final_sb_empty", 64'(exp_q.size()), 64'd0);
        chk64("final_no_steps_lost", 64'(got_sum), 64'(acc_sum));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
